// File: rtl/hex2ascii_pkg.sv
// Shared constants, FSM state encoding and character-count helper for the hex word formatter.
// HEX2ASCII_CRLF_EN selects a CR LF terminator instead of a single SEP character.
package hex2ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_e;

`ifdef HEX2ASCII_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif

  // Characters emitted per word: nibbles, optional inter-byte separators, terminator.
  function automatic int char_count(input int bytes, input int group, input int term);
    return 2 * bytes + group * (bytes - 1) + term;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit, letter case chosen by UPPER.
module hex_nibble_ascii
  import hex2ascii_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  localparam logic [7:0] LETTER_BASE = UPPER ? 8'h37 : 8'h57;

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASCII_ZERO + {4'h0, nibble_i};
    else                  ascii_o = LETTER_BASE + {4'h0, nibble_i};
  end

endmodule

// File: rtl/hex_word_2_ascii.sv
// Formats a BYTES-wide word as hex ASCII, one character per UART transfer (tx_start/tx_done).
// Define HEX2ASCII_CRLF_EN to terminate each word with CR LF instead of SEP.
module hex_word_2_ascii
  import hex2ascii_pkg::*;
#(
  parameter int         BYTES = 2,
  parameter bit         UPPER = 1'b1,
  parameter bit         GROUP = 1'b0,
  parameter logic [7:0] SEP   = ASCII_SP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               word_done,
  output logic [1:0]         dbg_state
);

  localparam int W      = 8 * BYTES;
  localparam int NB     = 2 * BYTES + (GROUP ? BYTES - 1 : 0);
  localparam int N      = char_count(BYTES, GROUP ? 1 : 0, TERM_LEN);
  localparam int IW     = $clog2(N + 1);
  localparam int STRIDE = GROUP ? 3 : 2;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  word_q, word_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_char;

  int            sel, byte_n, pos_n, shamt;
  logic [W-1:0]  shifted;
  logic [3:0]    nib;
  logic [7:0]    nib_ascii;
  logic [7:0]    char_d;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_valid with in_ready low is ignored, never queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign last_char = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (last_char) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    tx_start  = (state_q == S_SEND);
    word_done = (state_q == S_WAIT) && tx_done && last_char;
    tx_data   = tx_data_q;
    dbg_state = state_q;
  end

  // The character is computed from the next index/word so it is already
  // registered on tx_data during the SEND cycle.
  always_comb begin
    sel    = int'(idx_d);
    byte_n = sel / STRIDE;
    pos_n  = sel % STRIDE;
    shamt  = 0;
    if (sel < NB) shamt = 8 * (BYTES - 1 - byte_n) + ((pos_n == 0) ? 4 : 0);
    shifted = word_d >> shamt;
    nib     = shifted[3:0];
  end

  hex_nibble_ascii #(.UPPER(UPPER)) u_nibble (
    .nibble_i (nib),
    .ascii_o  (nib_ascii)
  );

  always_comb begin
    char_d = nib_ascii;
    if (sel >= NB) begin
`ifdef HEX2ASCII_CRLF_EN
      char_d = (sel == NB) ? ASCII_CR : ASCII_LF;
`else
      char_d = SEP;
`endif
    end else if (pos_n == 2) begin
      char_d = SEP;
    end
    tx_data_d = (state_d == S_SEND) ? char_d : tx_data_q;
  end

endmodule

// File: tb/tb_hex_word_2_ascii.sv
// Directed bench for hex_word_2_ascii: four instances with different parameters share one clock.
// Expected terminators follow HEX2ASCII_CRLF_EN when the bundle is built with it.
module tb_hex_word_2_ascii;

  logic             clk;
  logic             rst;
  logic [63:0]      in_data [4];
  logic [3:0]       in_valid;
  wire  [3:0]       in_ready;
  logic [3:0]       resp_done;
  logic [3:0]       spur;
  wire  [3:0]       tx_done;
  wire  [3:0]       tx_start;
  wire  [3:0]       word_done;
  logic [7:0]       tx_data [4];
  logic [1:0]       st [4];

  int               dly [4];
  int               cnt [4];
  logic [7:0]       got [4][64];
  int               got_n [4];
  int               wd_n [4];
  int               acc_n [4];
  int               stab_err [4];

  logic [7:0]       exp_q[$];
  int               n_chk;
  int               n_pass;
  int               n_fail;

  assign tx_done = resp_done | spur;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  hex_word_2_ascii #(.BYTES(2), .UPPER(1'b1), .GROUP(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data[0][15:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx_done(tx_done[0]), .tx_start(tx_start[0]),
    .tx_data(tx_data[0]), .word_done(word_done[0]), .dbg_state(st[0]));

  hex_word_2_ascii #(.BYTES(2), .UPPER(1'b0), .GROUP(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data[1][15:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx_done(tx_done[1]), .tx_start(tx_start[1]),
    .tx_data(tx_data[1]), .word_done(word_done[1]), .dbg_state(st[1]));

  hex_word_2_ascii #(.BYTES(4), .UPPER(1'b1), .GROUP(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data[2][31:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx_done(tx_done[2]), .tx_start(tx_start[2]),
    .tx_data(tx_data[2]), .word_done(word_done[2]), .dbg_state(st[2]));

  hex_word_2_ascii #(.BYTES(1), .UPPER(1'b1), .GROUP(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[3][7:0]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .tx_done(tx_done[3]), .tx_start(tx_start[3]),
    .tx_data(tx_data[3]), .word_done(word_done[3]), .dbg_state(st[3]));

  // ---------------- UART model: tx_done dly cycles after each tx_start ----------------
  initial begin
    resp_done = 4'b0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        resp_done[k] = 1'b0;
        if (cnt[k] > 0) begin
          cnt[k] = cnt[k] - 1;
          if (cnt[k] == 0) resp_done[k] = 1'b1;
        end
        if (tx_start[k] === 1'b1) cnt[k] = dly[k];
      end
    end
  end

  // ---------------- monitor: captures characters, pulses, accepts ----------------
  initial begin
    for (int k = 0; k < 4; k++) begin
      got_n[k] = 0; wd_n[k] = 0; acc_n[k] = 0; stab_err[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (st[k] == 2'd2 && got_n[k] > 0 && got_n[k] <= 64 &&
            tx_data[k] !== got[k][got_n[k]-1]) stab_err[k]++;
        if (tx_start[k] === 1'b1) begin
          if (got_n[k] < 64) got[k][got_n[k]] = tx_data[k];
          got_n[k]++;
        end
        if (word_done[k] === 1'b1) wd_n[k]++;
        if (in_valid[k] && in_ready[k] === 1'b1) acc_n[k]++;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_term();
`ifdef HEX2ASCII_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  // Sends one word to instance k and compares the emitted characters with exp_q.
  task automatic run_word(input int k, input logic [63:0] data, input bit hold, input string tag);
    int base, wd0, st0, ac0;
    bit seen;
    base = got_n[k]; wd0 = wd_n[k]; st0 = stab_err[k]; ac0 = acc_n[k];
    @(posedge clk);
    #1;
    in_data[k]  = data;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid[k] = 1'b0;
    @(negedge clk);
    chk({tag, ".first_start"}, 64'(tx_start[k]), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (word_done[k] === 1'b1) seen = 1'b1;
    end
    if (hold) in_valid[k] = 1'b0;
    #1;
    chk({tag, ".word_done_seen"}, 64'(seen), 64'd1);
    chk({tag, ".char_count"}, 64'(got_n[k] - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < 64) chk($sformatf("%s.chr%0d", tag, i), 64'(got[k][base+i]), 64'(exp_q[i]));
    chk({tag, ".word_done_pulses"}, 64'(wd_n[k] - wd0), 64'd1);
    chk({tag, ".tx_data_stable"}, 64'(stab_err[k] - st0), 64'd0);
    chk({tag, ".accepts"}, 64'(acc_n[k] - ac0), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int base, wd0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    in_valid = 4'b0;
    spur = 4'b0;
    for (int k = 0; k < 4; k++) in_data[k] = 64'd0;
    dly[0] = 5; dly[1] = 3; dly[2] = 2; dly[3] = 4;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset%0d.in_ready", k),  64'(in_ready[k]),  64'd1);
      chk($sformatf("reset%0d.tx_start", k),  64'(tx_start[k]),  64'd0);
      chk($sformatf("reset%0d.tx_data", k),   64'(tx_data[k]),   64'h00);
      chk($sformatf("reset%0d.word_done", k), 64'(word_done[k]), 64'd0);
      chk($sformatf("reset%0d.state", k),     64'(st[k]),        64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Upper case, no grouping
    exp_q = '{8'h33, 8'h41, 8'h46, 8'h30}; push_term();
    run_word(0, 64'h3AF0, 1'b0, "t1_3AF0");

    // Lower case letters
    exp_q = '{8'h30, 8'h30, 8'h66, 8'h66}; push_term();
    run_word(1, 64'h00FF, 1'b0, "t2_00FF");

    // Grouped 4-byte word, in_valid held high for the whole word
    exp_q = '{8'h31, 8'h32, 8'h20, 8'h33, 8'h34, 8'h20, 8'h35, 8'h36, 8'h20, 8'h37, 8'h38};
    push_term();
    run_word(2, 64'h12345678, 1'b1, "t3_12345678");

    // Spurious tx_done while idle, then back-to-back words with fast UART
    dly[0] = 1;
    base = got_n[0];
    @(posedge clk); #1 spur[0] = 1'b1;
    @(posedge clk); #1 spur[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_spur.state", 64'(st[0]), 64'd0);
    chk("t4_spur.in_ready", 64'(in_ready[0]), 64'd1);
    chk("t4_spur.no_chars", 64'(got_n[0] - base), 64'd0);
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h31}; push_term();
    run_word(0, 64'h0001, 1'b0, "t4_0001");
    exp_q = '{8'h42, 8'h45, 8'h45, 8'h46}; push_term();
    run_word(0, 64'hBEEF, 1'b0, "t4_BEEF");

    // Asynchronous reset during WAIT of the third character
    dly[0] = 5;
    base = got_n[0];
    wd0  = wd_n[0];
    @(posedge clk); #1;
    in_data[0]  = 64'h1234;
    in_valid[0] = 1'b1;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    for (int c = 0; c < 200 && (got_n[0] - base) < 3; c++) @(negedge clk);
    chk("t5.chars_before_rst", 64'(got_n[0] - base), 64'd3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5.async_in_ready",  64'(in_ready[0]),  64'd1);
    chk("t5.async_tx_start",  64'(tx_start[0]),  64'd0);
    chk("t5.async_tx_data",   64'(tx_data[0]),   64'h00);
    chk("t5.async_word_done", 64'(word_done[0]), 64'd0);
    chk("t5.async_state",     64'(st[0]),        64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("t5.no_word_done", 64'(wd_n[0] - wd0), 64'd0);
    exp_q = '{8'h33, 8'h41, 8'h46, 8'h30}; push_term();
    run_word(0, 64'h3AF0, 1'b0, "t5_after_rst");

    // Single-byte word; terminator depends on the build
    exp_q = '{8'h43, 8'h33}; push_term();
    run_word(3, 64'hC3, 1'b0, "t6_C3");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
